// File: rtl/arbitro_memoria_pkg.sv
// Shared definitions for the data-memory arbiter: FSM states, memory block
// control encoding and requester identifiers.
package arbitro_pkg;

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        ACESSO   = 2'd1,
        RESPOSTA = 2'd2
    } estado_t;

    // Memory block convention: 0 = write, 1 = read (idle level is read).
    localparam logic CTRL_ESCRITA = 1'b0;
    localparam logic CTRL_LEITURA = 1'b1;

    typedef enum logic {
        ID_IF  = 1'b0,
        ID_MEM = 1'b1
    } id_t;

endpackage

// File: rtl/arbitro_memoria_seletor_prioridade.sv
// Combinational winner select between IF and MEM requests.
// MEM wins ties; with ARB_ANTI_FOME_EN defined, IF is forced once the
// consecutive-MEM-grant counter reaches LIMITE_ESPERA.
import arbitro_pkg::*;

module seletor_prioridade
`ifdef ARB_ANTI_FOME_EN
#(
    parameter int LIMITE_ESPERA = 4,
    parameter int CW            = 3
)
`endif
(
    input  logic          if_req,
    input  logic          mem_req,
`ifdef ARB_ANTI_FOME_EN
    input  logic [CW-1:0] contador,
`endif
    output logic          valido,
    output id_t           vencedor
);

    logic forca_if;

    // Winner and request-present decode
    always_comb begin
        valido   = if_req | mem_req;
`ifdef ARB_ANTI_FOME_EN
        forca_if = if_req && (contador == CW'(LIMITE_ESPERA));
`else
        forca_if = 1'b0;
`endif
        vencedor = (mem_req && !forca_if) ? ID_MEM : ID_IF;
    end

endmodule

// File: rtl/arbitro_memoria.sv
// Arbiter/sequencer sharing the single-port data memory between the IF stage
// (read-only) and the MEM stage (read/write). One access at a time:
// OCIOSO -> ACESSO (LATENCIA cycles) -> RESPOSTA (one-cycle ack) -> OCIOSO.
// Optional macro ARB_ANTI_FOME_EN enables the IF anti-starvation counter;
// without it MEM has strict priority.
import arbitro_pkg::*;

module arbitro_memoria #(
    parameter int LARGURA       = 32,
    parameter int LATENCIA      = 2,
    parameter int LIMITE_ESPERA = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               if_req,
    input  logic [LARGURA-1:0] if_endereco,
    output logic [LARGURA-1:0] if_dado,
    output logic               if_ack,
    output logic               if_stall,
    input  logic               mem_req,
    input  logic               mem_escrita,
    input  logic [LARGURA-1:0] mem_endereco,
    input  logic [LARGURA-1:0] mem_valor,
    output logic [LARGURA-1:0] mem_dado,
    output logic               mem_ack,
    output logic               mem_stall,
    output logic [LARGURA-1:0] bloco_endereco,
    output logic [LARGURA-1:0] bloco_valor,
    output logic               bloco_controle,
    input  logic [LARGURA-1:0] bloco_saida,
    output logic               ocupado
);

    localparam int CNTW = (LATENCIA > 1) ? $clog2(LATENCIA) : 1;

    if (LATENCIA < 1 || LIMITE_ESPERA < 1) begin : g_parametro_invalido
        $error("arbitro_memoria: LATENCIA and LIMITE_ESPERA must be >= 1");
    end

    estado_t         estado, proximo;
    logic [CNTW-1:0] cnt;
    logic            escrita_reg;
    id_t             vencedor_reg;
    logic            grant_valido;
    id_t             grant_id;
    logic            conceder;

    assign conceder = (estado == OCIOSO) && grant_valido;

`ifdef ARB_ANTI_FOME_EN
    localparam int CW = $clog2(LIMITE_ESPERA + 1);
    logic [CW-1:0] contador;

    // Count consecutive MEM grants that left a pending IF request waiting
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            contador <= '0;
        end else if (!if_req) begin
            contador <= '0;
        end else if (conceder) begin
            if (grant_id == ID_IF)
                contador <= '0;
            else if (contador != CW'(LIMITE_ESPERA))
                contador <= contador + CW'(1);
        end
    end
`endif

    seletor_prioridade
`ifdef ARB_ANTI_FOME_EN
        #(.LIMITE_ESPERA(LIMITE_ESPERA), .CW(CW))
`endif
        u_seletor (
            .if_req   (if_req),
            .mem_req  (mem_req),
`ifdef ARB_ANTI_FOME_EN
            .contador (contador),
`endif
            .valido   (grant_valido),
            .vencedor (grant_id)
        );

    // FSM state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            estado <= OCIOSO;
        else
            estado <= proximo;
    end

    // Next-state logic; no new grant is launched from RESPOSTA
    always_comb begin
        proximo = estado;
        case (estado)
            OCIOSO:   if (grant_valido) proximo = ACESSO;
            ACESSO:   if (cnt == '0)    proximo = RESPOSTA;
            RESPOSTA: proximo = OCIOSO;
            default:  proximo = OCIOSO;
        endcase
    end

    // Latch the winner's request at grant; count latency and capture read data
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bloco_endereco <= '0;
            bloco_valor    <= '0;
            escrita_reg    <= 1'b0;
            vencedor_reg   <= ID_IF;
            cnt            <= '0;
            if_dado        <= '0;
            mem_dado       <= '0;
        end else if (conceder) begin
            vencedor_reg <= grant_id;
            cnt          <= CNTW'(LATENCIA - 1);
            if (grant_id == ID_MEM) begin
                bloco_endereco <= mem_endereco;
                bloco_valor    <= mem_valor;
                escrita_reg    <= mem_escrita;
            end else begin
                bloco_endereco <= if_endereco;
                bloco_valor    <= '0;
                escrita_reg    <= 1'b0;
            end
        end else if (estado == ACESSO) begin
            if (cnt != '0) begin
                cnt <= cnt - CNTW'(1);
            end else if (!escrita_reg) begin
                if (vencedor_reg == ID_MEM)
                    mem_dado <= bloco_saida;
                else
                    if_dado  <= bloco_saida;
            end
        end
    end

    // Acks, stalls and memory control decode from state and latched request
    always_comb begin
        if_ack         = (estado == RESPOSTA) && (vencedor_reg == ID_IF);
        mem_ack        = (estado == RESPOSTA) && (vencedor_reg == ID_MEM);
        if_stall       = if_req & ~if_ack;
        mem_stall      = mem_req & ~mem_ack;
        bloco_controle = ((estado == ACESSO) && escrita_reg) ? CTRL_ESCRITA : CTRL_LEITURA;
        ocupado        = (estado != OCIOSO);
    end

endmodule

// File: tb/tb_arbitro_memoria.sv
// Directed bench for arbitro_memoria (LATENCIA=2, LIMITE_ESPERA=4) with a
// small word-addressed memory block model attached to the bloco_* ports.
module tb_arbitro_memoria;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         if_req;
    logic [W-1:0] if_endereco;
    logic [W-1:0] if_dado;
    logic         if_ack;
    logic         if_stall;
    logic         mem_req;
    logic         mem_escrita;
    logic [W-1:0] mem_endereco;
    logic [W-1:0] mem_valor;
    logic [W-1:0] mem_dado;
    logic         mem_ack;
    logic         mem_stall;
    logic [W-1:0] bloco_endereco;
    logic [W-1:0] bloco_valor;
    logic         bloco_controle;
    logic [W-1:0] bloco_saida;
    logic         ocupado;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] ram [0:63];
    logic         pre_wr;
    logic [5:0]   pre_a;
    logic [W-1:0] pre_d;

    arbitro_memoria #(.LARGURA(W), .LATENCIA(2), .LIMITE_ESPERA(4)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .if_req         (if_req),
        .if_endereco    (if_endereco),
        .if_dado        (if_dado),
        .if_ack         (if_ack),
        .if_stall       (if_stall),
        .mem_req        (mem_req),
        .mem_escrita    (mem_escrita),
        .mem_endereco   (mem_endereco),
        .mem_valor      (mem_valor),
        .mem_dado       (mem_dado),
        .mem_ack        (mem_ack),
        .mem_stall      (mem_stall),
        .bloco_endereco (bloco_endereco),
        .bloco_valor    (bloco_valor),
        .bloco_controle (bloco_controle),
        .bloco_saida    (bloco_saida),
        .ocupado        (ocupado)
    );

    always #5 clock = ~clock;

    // Memory block model: combinational read, write on rising edge when controle=0
    assign bloco_saida = ram[bloco_endereco[5:0]];
    always @(posedge clock) begin
        if (pre_wr)
            ram[pre_a] <= pre_d;
        else if (bloco_controle == 1'b0)
            ram[bloco_endereco[5:0]] <= bloco_valor;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [5:0] a, input logic [W-1:0] d);
        pre_wr = 1'b1;
        pre_a  = a;
        pre_d  = d;
        tick();
        pre_wr = 1'b0;
    endtask

    initial begin
        int wr_ciclos;
        int acks;
        logic exp_if;

        reset_n = 1'b0;
        if_req = 1'b0; if_endereco = '0;
        mem_req = 1'b0; mem_escrita = 1'b0; mem_endereco = '0; mem_valor = '0;
        pre_wr = 1'b0; pre_a = '0; pre_d = '0;
        #2;
        preload(6'd4,  32'h8C01_0004);
        preload(6'd8,  32'h1234_5678);
        preload(6'd16, 32'h0000_0000);
        preload(6'd32, 32'h1111_1111);

        // Reset state
        chk("rst_if_ack",   if_ack, 0);
        chk("rst_mem_ack",  mem_ack, 0);
        chk("rst_controle", bloco_controle, 1);
        chk("rst_ocupado",  ocupado, 0);
        chk("rst_if_dado",  if_dado, 0);
        chk("rst_mem_dado", mem_dado, 0);
        chk("rst_endereco", bloco_endereco, 0);
        reset_n = 1'b1;
        tick();

        // IF read of word 0x4
        if_req = 1'b1; if_endereco = 32'h4;
        #1;
        chk("t2_stall_c0", if_stall, 1);
        chk("t2_ocup_c0",  ocupado, 0);
        tick();
        chk("t2_stall_c1", if_stall, 1);
        chk("t2_ocup_c1",  ocupado, 1);
        chk("t2_end_c1",   bloco_endereco, 32'h4);
        chk("t2_ctrl_c1",  bloco_controle, 1);
        chk("t2_ack_c1",   if_ack, 0);
        tick();
        chk("t2_stall_c2", if_stall, 1);
        chk("t2_ack_c2",   if_ack, 0);
        tick();
        chk("t2_ack_c3",   if_ack, 1);
        chk("t2_dado_c3",  if_dado, 32'h8C01_0004);
        chk("t2_stall_c3", if_stall, 0);
        if_req = 1'b0;
        tick();
        chk("t2_ack_c4",   if_ack, 0);
        chk("t2_ocup_c4",  ocupado, 0);

        // Simultaneous IF read 0x8 and MEM write 0x10 (MEM wins the tie)
        if_req = 1'b1; if_endereco = 32'h8;
        mem_req = 1'b1; mem_escrita = 1'b1; mem_endereco = 32'h10; mem_valor = 32'hDEAD_BEEF;
        #1;
        chk("t3_mstall_c0", mem_stall, 1);
        wr_ciclos = 0;
        for (int c = 0; c < 8; c++) begin
            if (bloco_controle == 1'b0) wr_ciclos++;
            chk($sformatf("t3_mem_ack_c%0d", c), mem_ack, (c == 3) ? 1 : 0);
            chk($sformatf("t3_if_ack_c%0d", c),  if_ack,  (c == 7) ? 1 : 0);
            if (c == 3) begin
                chk("t3_mem_dado_wr", mem_dado, 0);
                mem_req = 1'b0; mem_escrita = 1'b0;
            end
            if (c == 7) begin
                chk("t3_if_dado", if_dado, 32'h1234_5678);
                if_req = 1'b0;
            end
            tick();
        end
        chk("t3_ciclos_escrita", wr_ciclos, 2);
        mem_req = 1'b1; mem_escrita = 1'b0; mem_endereco = 32'h10;
        tick(); tick(); tick();
        chk("t3_rd_ack",  mem_ack, 1);
        chk("t3_rd_dado", mem_dado, 32'hDEAD_BEEF);
        mem_req = 1'b0;
        tick();

        // Both requests held high: starvation behaviour
        if_req = 1'b1; if_endereco = 32'h4;
        mem_req = 1'b1; mem_escrita = 1'b0; mem_endereco = 32'h8;
        for (int g = 0; g < 20; g++) begin
            tick(); tick(); tick();
`ifdef ARB_ANTI_FOME_EN
            exp_if = ((g % 5) == 4);
`else
            exp_if = 1'b0;
`endif
            chk($sformatf("t4_if_ack_g%0d", g),  if_ack,  exp_if);
            chk($sformatf("t4_mem_ack_g%0d", g), mem_ack, !exp_if);
            tick();
        end
        if_req = 1'b0; mem_req = 1'b0;
        tick();
        chk("t4_ocup_fim", ocupado, 0);

        // Reset pulsed during ACESSO of a write
        mem_req = 1'b1; mem_escrita = 1'b1; mem_endereco = 32'h20; mem_valor = 32'hCAFE_F00D;
        tick();
        chk("t5_ctrl_acesso", bloco_controle, 0);
        reset_n = 1'b0;
        #1;
        chk("t5_rst_ack",      mem_ack, 0);
        chk("t5_rst_ctrl",     bloco_controle, 1);
        chk("t5_rst_ocup",     ocupado, 0);
        chk("t5_rst_end",      bloco_endereco, 0);
        chk("t5_rst_valor",    bloco_valor, 0);
        chk("t5_rst_mem_dado", mem_dado, 0);
        chk("t5_rst_if_dado",  if_dado, 0);
        mem_req = 1'b0; mem_escrita = 1'b0;
        tick();
        chk("t5_rst_ack2", mem_ack, 0);
        reset_n = 1'b1;
        tick();
        if_req = 1'b1; if_endereco = 32'h20;
        tick(); tick();
        chk("t5_if_ack_c2", if_ack, 0);
        tick();
        chk("t5_if_ack_c3", if_ack, 1);
        chk("t5_if_dado",   if_dado, 32'h1111_1111);
        if_req = 1'b0;
        tick();

        // mem_req dropped during ACESSO
        mem_req = 1'b1; mem_escrita = 1'b0; mem_endereco = 32'h8;
        tick();
        mem_req = 1'b0;
        #1;
        chk("t6_stall_sem_req", mem_stall, 0);
        acks = 0;
        for (int c = 0; c < 5; c++) begin
            if (mem_ack) acks++;
            if (c == 2) chk("t6_mem_dado", mem_dado, 32'h1234_5678);
            tick();
        end
        chk("t6_acks", acks, 1);
        chk("t6_ocup", ocupado, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
